// File: rtl/tag_free_list_16_pkg.sv
// -----------------------------------------------------------------------------
// tag_free_list_16_pkg
// Shared constants and reset-value helpers for the 16-entry tag free list.
//   TAG_NUM / TAG_IDX_W / TAG_CNT_W : tag count, tag index width, counter width
//   TAG_RST_MASK(reserve0)          : free mask after reset or flush
//   TAG_RST_CNT(reserve0)           : free count after reset or flush
// -----------------------------------------------------------------------------
package tag_free_list_16_pkg;

    localparam int TAG_NUM   = 16;
    localparam int TAG_IDX_W = 4;
    localparam int TAG_CNT_W = 5;

    // Tag 0 is held back from the pool when it is the hard-wired tag.
    function automatic logic [TAG_NUM-1:0] TAG_RST_MASK(input bit reserve0);
        return reserve0 ? 16'hFFFE : 16'hFFFF;
    endfunction

    function automatic logic [TAG_CNT_W-1:0] TAG_RST_CNT(input bit reserve0);
        return reserve0 ? 5'd15 : 5'd16;
    endfunction

endpackage

// File: rtl/tag_free_list_16_if.sv
// -----------------------------------------------------------------------------
// tag_free_list_16_if
// Bundles the allocate / free / flush traffic of the tag free list.
//   master : consumer side (drives alloc_req, free_vld, free_idx, flush)
//   slave  : free list side (drives grant, index, count and status flags)
//
// Handshake: alloc_req behaves as a valid and alloc_gnt as its same-cycle
// ready; a tag changes hands only in a cycle where both are 1, and alloc_idx
// is meaningful only then (it reads 0 otherwise). free_vld is a valid with no
// back-pressure: the free list always takes it in the same cycle, and an
// illegal release is dropped and reported one cycle later on err_dfree.
// dbg_free_mask mirrors the internal free mask (1 = free) for observation.
// -----------------------------------------------------------------------------
interface tag_free_list_16_if;
    import tag_free_list_16_pkg::*;

    logic                 alloc_req;
    logic                 alloc_gnt;
    logic [TAG_IDX_W-1:0] alloc_idx;
    logic                 free_vld;
    logic [TAG_IDX_W-1:0] free_idx;
    logic                 flush;
    logic [TAG_CNT_W-1:0] free_cnt;
    logic                 empty;
    logic                 all_free;
    logic                 err_dfree;
    logic [TAG_NUM-1:0]   dbg_free_mask;

    modport master (
        output alloc_req, free_vld, free_idx, flush,
        input  alloc_gnt, alloc_idx, free_cnt, empty, all_free, err_dfree,
               dbg_free_mask
    );

    modport slave (
        input  alloc_req, free_vld, free_idx, flush,
        output alloc_gnt, alloc_idx, free_cnt, empty, all_free, err_dfree,
               dbg_free_mask
    );

endinterface

// File: rtl/tag_free_list_16_pri_enc_16_4.sv
// -----------------------------------------------------------------------------
// pri_enc_16_4
// Combinational lowest-set-bit encoder.
//   in  [15:0] : request vector
//   idx [3:0]  : index of the lowest set bit of in (0 when in == 0)
//   vld        : at least one bit of in is set
// -----------------------------------------------------------------------------
module pri_enc_16_4
    import tag_free_list_16_pkg::*;
(
    input  logic [TAG_NUM-1:0]   in,
    output logic [TAG_IDX_W-1:0] idx,
    output logic                 vld
);

    // Scan from the top down so the last hit, i.e. the lowest bit, wins.
    always_comb begin
        idx = '0;
        for (int i = TAG_NUM - 1; i >= 0; i--) begin
            if (in[i]) idx = TAG_IDX_W'(i);
        end
    end

    assign vld = |in;

endmodule

// File: rtl/tag_free_list_16.sv
// -----------------------------------------------------------------------------
// tag_free_list_16
// Tracks which of 16 physical tags are free, grants the lowest-numbered free
// tag on request (zero latency) and takes tags back on release. flush returns
// every tag to the pool.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : tag_free_list_16_if.slave
//              alloc_req/alloc_gnt/alloc_idx : allocation
//              free_vld/free_idx             : release
//              flush                         : return all tags
//              free_cnt/empty/all_free       : registered pool status
//              err_dfree                     : one-cycle illegal-free pulse
//              dbg_free_mask                 : internal free mask
// Parameters
//   NUM_ENTRIES    : must be 16
//   RESERVE_ENTRY0 : 1 keeps tag 0 out of the pool permanently
// -----------------------------------------------------------------------------
module tag_free_list_16
    import tag_free_list_16_pkg::*;
#(
    parameter int NUM_ENTRIES    = 16,
    parameter bit RESERVE_ENTRY0 = 1'b0
) (
    input logic              clk,
    input logic              rst,
    tag_free_list_16_if.slave bus
);

    if (NUM_ENTRIES != TAG_NUM) begin : g_bad_num_entries
        $error("tag_free_list_16 supports NUM_ENTRIES == 16 only");
    end

    localparam logic [TAG_NUM-1:0]   RST_MASK = TAG_RST_MASK(RESERVE_ENTRY0);
    localparam logic [TAG_CNT_W-1:0] RST_CNT  = TAG_RST_CNT(RESERVE_ENTRY0);

    logic [TAG_NUM-1:0]   free_mask;
    logic [TAG_CNT_W-1:0] free_cnt;
    logic                 err_dfree;

    logic [TAG_IDX_W-1:0] enc_idx;
    logic                 enc_vld;
    logic                 gnt;
    logic                 free_ok;
    logic                 free_bad;
    logic [TAG_NUM-1:0]   mask_nxt;
    logic [TAG_CNT_W-1:0] cnt_nxt;

    pri_enc_16_4 u_pri_enc (
        .in  (free_mask),
        .idx (enc_idx),
        .vld (enc_vld)
    );

    // Grant looks only at the registered mask, so a tag released this cycle
    // is not visible to the allocator until the next one.
    assign gnt = bus.alloc_req & enc_vld & ~bus.flush & ~rst;

    // A release is legal only for a busy tag, and never for the hard-wired
    // tag 0 when it is reserved.
    assign free_ok  = bus.free_vld & ~free_mask[bus.free_idx]
                    & ~(RESERVE_ENTRY0 && (bus.free_idx == '0));
    assign free_bad = bus.free_vld & ~free_ok;

    // A grant clears a free bit and an accepted release sets a busy bit, so
    // when both happen together they always touch different tags.
    always_comb begin
        mask_nxt = free_mask;
        cnt_nxt  = free_cnt;
        if (gnt)     mask_nxt[enc_idx]      = 1'b0;
        if (free_ok) mask_nxt[bus.free_idx] = 1'b1;
        case ({gnt, free_ok})
            2'b10:   cnt_nxt = free_cnt - 1'b1;
            2'b01:   cnt_nxt = free_cnt + 1'b1;
            default: cnt_nxt = free_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            free_mask <= RST_MASK;
            free_cnt  <= RST_CNT;
            err_dfree <= 1'b0;
        end else begin
            free_mask <= mask_nxt;
            free_cnt  <= cnt_nxt;
            err_dfree <= free_bad;
        end
    end

    assign bus.alloc_gnt     = gnt;
    assign bus.alloc_idx     = gnt ? enc_idx : '0;
    assign bus.free_cnt      = free_cnt;
    assign bus.empty         = (free_cnt == '0);
    assign bus.all_free      = (free_cnt == RST_CNT);
    assign bus.err_dfree     = err_dfree;
    assign bus.dbg_free_mask = free_mask;

    // The counter is a cached popcount of the mask and must never drift.
    a_cnt_matches_mask : assert property (
        @(posedge clk) disable iff (rst)
        free_cnt == TAG_CNT_W'($countones(free_mask))
    );

endmodule

// File: tb/tb_tag_free_list_16.sv
module tb_tag_free_list_16;
  import tag_free_list_16_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tag_free_list_16_if bus0 ();
  tag_free_list_16_if bus1 ();

  tag_free_list_16 #(.NUM_ENTRIES(16), .RESERVE_ENTRY0(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  tag_free_list_16 #(.NUM_ENTRIES(16), .RESERVE_ENTRY0(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive0(input logic req, input logic fv, input logic [3:0] fi, input logic fl);
    bus0.alloc_req = req;
    bus0.free_vld  = fv;
    bus0.free_idx  = fi;
    bus0.flush     = fl;
  endtask

  task automatic drive1(input logic req, input logic fv, input logic [3:0] fi, input logic fl);
    bus1.alloc_req = req;
    bus1.free_vld  = fv;
    bus1.free_idx  = fi;
    bus1.flush     = fl;
  endtask

  // Inputs change on the falling edge; the DUT samples on the rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive0(1'b1, 1'b0, 4'd0, 1'b0);
    drive1(1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    chk("gnt_in_rst0", bus0.alloc_gnt, 0);
    chk("gnt_in_rst1", bus1.alloc_gnt, 0);
    tick();
    rst = 1'b0;
    drive0(1'b0, 1'b0, 4'd0, 1'b0);
    drive1(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic       req;
    logic       fv;
    logic [3:0] fi;
    logic       fl;
    logic       exp_gnt;
    logic [3:0] exp_idx;
    logic [4:0] exp_cnt;
    logic       exp_err;
  } vec_t;

  vec_t vecs[25];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive0(1'b0, 1'b0, 4'd0, 1'b0);
    drive1(1'b0, 1'b0, 4'd0, 1'b0);

    // Drain the pool in order, then release 9, re-grant it, then exercise
    // a legal and an illegal release of tag 12.
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'(i), 5'(16 - i), 1'b0};
    vecs[16] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  5'd0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 4'd0,  5'd0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 4'd9,  5'd1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 4'd0,  5'd0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 4'd0,  5'd1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  5'd1, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  5'd1, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 4'd12, 5'd1, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  5'd0, 1'b0};

    @(negedge clk);

    // ---- reset state
    do_reset();
    #1;
    chk("rst_cnt", bus0.free_cnt, 16);
    chk("rst_mask", bus0.dbg_free_mask, 16'hFFFF);
    chk("rst_empty", bus0.empty, 0);
    chk("rst_all_free", bus0.all_free, 1);
    chk("rst_err", bus0.err_dfree, 0);
    chk("rst_idx_idle", bus0.alloc_idx, 0);

    // ---- table: drain, refill 9, double free of 12
    for (int v = 0; v < 25; v++) begin
      drive0(vecs[v].req, vecs[v].fv, vecs[v].fi, vecs[v].fl);
      #1;
      chk($sformatf("v%0d_gnt", v), bus0.alloc_gnt, vecs[v].exp_gnt);
      chk($sformatf("v%0d_idx", v), bus0.alloc_idx, vecs[v].exp_idx);
      chk($sformatf("v%0d_cnt", v), bus0.free_cnt, vecs[v].exp_cnt);
      chk($sformatf("v%0d_err", v), bus0.err_dfree, vecs[v].exp_err);
      chk($sformatf("v%0d_empty", v), bus0.empty, vecs[v].exp_cnt == 5'd0);
      chk($sformatf("v%0d_all_free", v), bus0.all_free, vecs[v].exp_cnt == 5'd16);
      tick();
    end
    drive0(1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("tbl_end_mask", bus0.dbg_free_mask, 16'h0000);

    // ---- simultaneous grant and free
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b0, 4'd0, 1'b0);
      tick();
    end
    drive0(1'b1, 1'b1, 4'd2, 1'b0);
    #1;
    chk("sim_gnt", bus0.alloc_gnt, 1);
    chk("sim_idx", bus0.alloc_idx, 4);
    chk("sim_cnt_before", bus0.free_cnt, 12);
    tick();
    drive0(1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("sim_mask", bus0.dbg_free_mask, 16'hFFE4);
    chk("sim_cnt_after", bus0.free_cnt, 12);
    chk("sim_err", bus0.err_dfree, 0);
    drive0(1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    chk("sim_regrant_idx", bus0.alloc_idx, 2);
    tick();
    drive0(1'b0, 1'b0, 4'd0, 1'b0);

    // ---- flush while allocating and freeing
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive0(1'b1, 1'b0, 4'd0, 1'b0);
      tick();
    end
    drive0(1'b1, 1'b1, 4'd10, 1'b1);
    #1;
    chk("flush_gnt", bus0.alloc_gnt, 0);
    chk("flush_idx", bus0.alloc_idx, 0);
    chk("flush_cnt_before", bus0.free_cnt, 9);
    tick();
    drive0(1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("flush_cnt", bus0.free_cnt, 16);
    chk("flush_all_free", bus0.all_free, 1);
    chk("flush_err", bus0.err_dfree, 0);
    chk("flush_mask", bus0.dbg_free_mask, 16'hFFFF);

    // ---- reset mid-allocation
    for (int i = 0; i < 5; i++) begin
      drive0(1'b1, 1'b0, 4'd0, 1'b0);
      tick();
    end
    #1;
    chk("midrst_cnt_before", bus0.free_cnt, 11);
    do_reset();
    #1;
    chk("midrst_cnt", bus0.free_cnt, 16);
    chk("midrst_all_free", bus0.all_free, 1);
    chk("midrst_mask", bus0.dbg_free_mask, 16'hFFFF);
    chk("midrst_err", bus0.err_dfree, 0);
    drive0(1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    chk("midrst_first_idx", bus0.alloc_idx, 0);
    chk("midrst_first_gnt", bus0.alloc_gnt, 1);
    tick();
    drive0(1'b0, 1'b0, 4'd0, 1'b0);

    // ---- reserved tag 0
    do_reset();
    #1;
    chk("rsv_rst_cnt", bus1.free_cnt, 15);
    chk("rsv_rst_mask", bus1.dbg_free_mask, 16'hFFFE);
    chk("rsv_all_free", bus1.all_free, 1);
    chk("rsv_empty", bus1.empty, 0);
    drive1(1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    chk("rsv_first_gnt", bus1.alloc_gnt, 1);
    chk("rsv_first_idx", bus1.alloc_idx, 1);
    tick();
    drive1(1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    drive1(1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("rsv_free0_err", bus1.err_dfree, 1);
    chk("rsv_free0_cnt", bus1.free_cnt, 14);
    chk("rsv_free0_mask", bus1.dbg_free_mask, 16'hFFFC);
    tick();
    #1;
    chk("rsv_err_pulse_end", bus1.err_dfree, 0);
    for (int i = 2; i < 16; i++) begin
      drive1(1'b1, 1'b0, 4'd0, 1'b0);
      #1;
      chk($sformatf("rsv_drain_idx%0d", i), bus1.alloc_idx, i);
      tick();
    end
    drive1(1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    chk("rsv_empty_gnt", bus1.alloc_gnt, 0);
    chk("rsv_empty_idx", bus1.alloc_idx, 0);
    chk("rsv_empty_cnt", bus1.free_cnt, 0);
    chk("rsv_empty_flag", bus1.empty, 1);
    tick();
    drive1(1'b0, 1'b0, 4'd0, 1'b0);

    // ---- final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
